// File: rtl/apuf_seq_pkg.sv
// Shared types and constants for the arbiter-PUF evaluation sequencer.
package apuf_seq_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    FIRE,
    WAIT,
    NEXT,
    FINISH
  } seqState_t;

  // A count strictly above this value is a majority of nrep evaluations.
  function automatic logic [CNT_W-1:0] majThreshold(input int nrep);
    return CNT_W'(nrep / 2);
  endfunction

endpackage

// File: rtl/apuf_chal_reg.sv
// Byte-addressed challenge register; clear beats write, both frozen while a run is active.
module apuf_chal_reg #(
  parameter  int N    = 64,
  localparam int IdxW = $clog2(N / 8)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      chal_byte,
  input  logic [IdxW-1:0] chal_idx,
  input  logic            chal_wr,
  input  logic            chal_clr,
  input  logic            freeze,
  output logic [N-1:0]    challenge
);

  localparam int Slots = 2 ** IdxW;

  // Marks which encodable byte indices actually exist in the register.
  function automatic logic [Slots-1:0] slotMask();
    logic [Slots-1:0] m;
    for (int i = 0; i < Slots; i++) m[i] = (i < N / 8);
    return m;
  endfunction

  localparam logic [Slots-1:0] ValidSlot = slotMask();

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      challenge <= '0;
    end else if (!freeze) begin
      if (chal_clr) begin
        challenge <= '0;
      end else if (chal_wr && ValidSlot[chal_idx]) begin
        challenge[8*chal_idx +: 8] <= chal_byte;
      end
    end
  end

endmodule

// File: rtl/apuf_eval_sequencer.sv
// Drives NREP trigger cycles into the XOR arbiter PUF and majority-votes the responses.
module apuf_eval_sequencer
  import apuf_seq_pkg::*;
#(
  parameter  int N       = 64,
  parameter  int K       = 6,
  parameter  int NREP    = 15,
  parameter  int TIG_CYC = 8,
  parameter  int GAP_CYC = 16,
  parameter  int TMO_CYC = 255,
  localparam int IdxW    = $clog2(N / 8)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      chal_byte,
  input  logic [IdxW-1:0] chal_idx,
  input  logic            chal_wr,
  input  logic            chal_clr,
  input  logic            start,
  output logic            busy,
  output logic [N-1:0]    puf_challenge,
  output logic            puf_tig,
  input  logic            puf_resp_ready,
  input  logic            puf_resp_bit,
  input  logic [K-1:0]    puf_resp_bits,
  output logic            done,
  output logic            resp_maj,
  output logic [7:0]      resp_ones,
  output logic [K-1:0]    resp_bits_maj,
  output logic            timeout_err
);

  localparam logic [CNT_W-1:0] MajThr = majThreshold(NREP);
  localparam logic [CNT_W-1:0] GapEnd = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TigEnd = CNT_W'(TIG_CYC - 1);
  localparam logic [CNT_W-1:0] TmoEnd = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] RepEnd = CNT_W'(NREP);

  seqState_t        state, nextState;
  logic [CNT_W-1:0] cycCnt;
  logic [CNT_W-1:0] repCnt;
  logic [CNT_W-1:0] onesCnt;
  logic [CNT_W-1:0] bitCnt [K];
  logic             tmoHit;
  logic             timerClr;

  apuf_chal_reg #(.N(N)) uChalReg (
    .clk       (clk),
    .rst_n     (rst_n),
    .chal_byte (chal_byte),
    .chal_idx  (chal_idx),
    .chal_wr   (chal_wr),
    .chal_clr  (chal_clr),
    .freeze    (busy),
    .challenge (puf_challenge)
  );

  assign busy     = (state != IDLE);
  assign puf_tig  = (state == FIRE) || (state == WAIT);
  assign timerClr = (nextState != state);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    nextState = state;
    tmoHit    = 1'b0;
    case (state)
      IDLE:   if (start) nextState = SETTLE;
      SETTLE: if (cycCnt == GapEnd) nextState = FIRE;
      FIRE:   if (cycCnt == TigEnd) nextState = WAIT;
      WAIT: begin
        if (puf_resp_ready) begin
          nextState = NEXT;
        end else if (cycCnt == TmoEnd) begin
          nextState = FINISH;
          tmoHit    = 1'b1;
        end
      end
      NEXT:    nextState = (repCnt + 1'b1 == RepEnd) ? FINISH : SETTLE;
      FINISH:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // The per-APUF counters are few and narrow, so they share the async reset with the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cycCnt        <= '0;
      repCnt        <= '0;
      onesCnt       <= '0;
      for (int j = 0; j < K; j++) bitCnt[j] <= '0;
      done          <= 1'b0;
      resp_maj      <= 1'b0;
      resp_ones     <= '0;
      resp_bits_maj <= '0;
      timeout_err   <= 1'b0;
    end else begin
      state  <= nextState;
      cycCnt <= timerClr ? '0 : cycCnt + 1'b1;
      done   <= (state == FINISH);

      if (state == IDLE && start) begin
        repCnt      <= '0;
        onesCnt     <= '0;
        for (int j = 0; j < K; j++) bitCnt[j] <= '0;
        timeout_err <= 1'b0;
      end

      if (state == WAIT && puf_resp_ready) begin
        onesCnt <= onesCnt + CNT_W'(puf_resp_bit);
        for (int j = 0; j < K; j++) bitCnt[j] <= bitCnt[j] + CNT_W'(puf_resp_bits[j]);
      end

      if (tmoHit) timeout_err <= 1'b1;
      if (state == NEXT) repCnt <= repCnt + 1'b1;

      if (state == FINISH) begin
        resp_ones <= onesCnt;
        resp_maj  <= (onesCnt > MajThr);
        for (int j = 0; j < K; j++) resp_bits_maj[j] <= (bitCnt[j] > MajThr);
      end
    end
  end

endmodule

// File: tb/tb_apuf_eval_sequencer.sv
// Scoreboard bench: runs push expected results, a done-triggered monitor pops and compares.
module tb_apuf_eval_sequencer;

  localparam int N    = 64;
  localparam int K    = 6;
  localparam int NREP = 15;
  localparam int TIG  = 8;
  localparam int GAP  = 16;
  localparam int TMO  = 255;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   chal_byte = '0;
  logic [2:0]   chal_idx = '0;
  logic         chal_wr = 1'b0;
  logic         chal_clr = 1'b0;
  logic         start = 1'b0;
  logic         busy;
  logic [N-1:0] puf_challenge;
  logic         puf_tig;
  logic         puf_resp_ready = 1'b0;
  logic         puf_resp_bit = 1'b0;
  logic [K-1:0] puf_resp_bits = '0;
  logic         done;
  logic         resp_maj;
  logic [7:0]   resp_ones;
  logic [K-1:0] resp_bits_maj;
  logic         timeout_err;

  apuf_eval_sequencer #(
    .N(N), .K(K), .NREP(NREP), .TIG_CYC(TIG), .GAP_CYC(GAP), .TMO_CYC(TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .chal_byte      (chal_byte),
    .chal_idx       (chal_idx),
    .chal_wr        (chal_wr),
    .chal_clr       (chal_clr),
    .start          (start),
    .busy           (busy),
    .puf_challenge  (puf_challenge),
    .puf_tig        (puf_tig),
    .puf_resp_ready (puf_resp_ready),
    .puf_resp_bit   (puf_resp_bit),
    .puf_resp_bits  (puf_resp_bits),
    .done           (done),
    .resp_maj       (resp_maj),
    .resp_ones      (resp_ones),
    .resp_bits_maj  (resp_bits_maj),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  int cycCnt = 0;
  always @(posedge clk) cycCnt <= cycCnt + 1;

  int nChecks = 0;
  int nPass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    string        name;
    int           ones;
    bit           maj;
    logic [K-1:0] bitsMaj;
    bit           tmo;
    int           doneCyc;
  } exp_t;

  exp_t sbQ[$];

  // PUF model: ready comes readyR cycles into WAIT (or with the trigger when readyEarly).
  bit          readyEn = 1'b1;
  bit          readyEarly = 1'b0;
  int          readyR = 3;
  logic [15:0] xorPat = '0;
  logic [15:0] a2Pat = '0;
  int          hiCnt = 0;
  int          evalIdx = 0;
  logic        tigD = 1'b0;

  always @(negedge clk) begin
    if (!busy) evalIdx = 0;
    else if (tigD && !puf_tig) evalIdx++;
    tigD  = puf_tig;
    hiCnt = puf_tig ? hiCnt + 1 : 0;
    puf_resp_ready = readyEn && (readyEarly ? puf_tig : (hiCnt >= TIG + readyR));
    puf_resp_bit   = xorPat[evalIdx[3:0]];
    puf_resp_bits  = {3'b000, a2Pat[evalIdx[3:0]], 1'b0, 1'b1};
  end

  exp_t monE;
  logic doneD = 1'b0;

  always @(negedge clk) begin
    if (doneD) check("done_pulse_width", done, 0);
    if (done) begin
      if (sbQ.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        monE = sbQ.pop_front();
        check({monE.name, "_ones"}, resp_ones, monE.ones);
        check({monE.name, "_maj"}, resp_maj, monE.maj);
        check({monE.name, "_bits_maj"}, resp_bits_maj, monE.bitsMaj);
        check({monE.name, "_timeout_err"}, timeout_err, monE.tmo);
        check({monE.name, "_done_cycle"}, cycCnt, monE.doneCyc);
        check({monE.name, "_busy_at_done"}, busy, 0);
      end
    end
    doneD = done;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic writeByte(input logic [2:0] idx, input logic [7:0] val);
    chal_idx  = idx;
    chal_byte = val;
    chal_wr   = 1'b1;
    tick();
    chal_wr   = 1'b0;
  endtask

  // Latency counts from the edge that samples start through the edge that registers done.
  task automatic startRun(input string name, input int ones, input bit maj,
                          input logic [K-1:0] bitsMaj, input bit tmo, input int lat);
    exp_t e;
    e.name    = name;
    e.ones    = ones;
    e.maj     = maj;
    e.bitsMaj = bitsMaj;
    e.tmo     = tmo;
    e.doneCyc = cycCnt + lat;
    sbQ.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    check({name, "_idle_within_budget"}, busy, 0);
    tick(2);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_tig", puf_tig, 0);
    check("rst_challenge", puf_challenge, 0);
    check("rst_results", {done, resp_maj, resp_ones, resp_bits_maj, timeout_err}, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) writeByte(3'(i), 8'(i + 1));
    check("chal_bytes", puf_challenge, 64'h0807060504030201);
    chal_clr = 1'b1;
    tick();
    chal_clr = 1'b0;
    check("chal_clr", puf_challenge, 0);
    chal_clr = 1'b1;
    writeByte(3'd3, 8'h77);
    chal_clr = 1'b0;
    check("chal_clr_beats_wr", puf_challenge, 0);

    xorPat = 16'h01FF;  // 9 of 15 ones
    a2Pat  = 16'h007F;  // 7 of 15 ones
    startRun("runA", 9, 1'b1, 6'b000001, 1'b0, NREP * (GAP + TIG + 3 + 1) + 2);
    waitIdle("runA");

    xorPat = 16'h007F;  // 7 of 15 ones
    a2Pat  = 16'h00FF;  // 8 of 15 ones
    startRun("runB", 7, 1'b0, 6'b000101, 1'b0, NREP * (GAP + TIG + 3 + 1) + 2);
    waitIdle("runB");

    readyEn = 1'b0;
    startRun("tmo", 0, 1'b0, 6'b000000, 1'b1, GAP + TIG + TMO + 2);
    waitIdle("tmo");
    readyEn = 1'b1;

    // Ready held through FIRE must only be taken on the first WAIT cycle.
    readyEarly = 1'b1;
    xorPat     = 16'h7FFF;
    a2Pat      = 16'h0000;
    chal_idx   = 3'd0;
    chal_byte  = 8'hAA;
    chal_wr    = 1'b1;
    startRun("runD", 15, 1'b1, 6'b000001, 1'b0, NREP * (GAP + TIG + 1 + 1) + 2);
    chal_wr = 1'b0;
    tick(3);
    check("start_clears_timeout", timeout_err, 0);
    check("wr_with_start_lands", puf_challenge, 64'hAA);
    chal_byte = 8'hFF;
    chal_wr   = 1'b1;
    start     = 1'b1;
    tick();
    chal_wr   = 1'b0;
    start     = 1'b0;
    chal_clr  = 1'b1;
    tick();
    chal_clr  = 1'b0;
    check("chal_frozen_while_busy", puf_challenge, 64'hAA);
    waitIdle("runD");
    tick(5);
    check("start_while_busy_ignored", busy, 0);
    readyEarly = 1'b0;

    xorPat  = 16'h01FF;
    readyEn = 1'b0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int n = 0; n < 100 && !puf_tig; n++) tick();
    tick(TIG + 2);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_tig", puf_tig, 0);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_outputs", {done, puf_challenge, timeout_err}, 0);
    tick(3);
    rst_n   = 1'b1;
    readyEn = 1'b1;
    tick();

    xorPat = 16'h01FF;
    a2Pat  = 16'h007F;
    startRun("runE", 9, 1'b1, 6'b000001, 1'b0, NREP * (GAP + TIG + 3 + 1) + 2);
    waitIdle("runE");

    check("scoreboard_drained", sbQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
